video_tpg: RTL and testbench
============================

VIDEO_TPG -- requirements
Module: video_tpg

Interface
REQ-001 Parameter DATA_W, default 16, pixel width in RGB565 format.
REQ-002 Parameter DIM_W, default 12, width of the line and pixel counters.
REQ-003 ACLK  input  1  single clock for all logic.
REQ-004 ARESETn  input  1  reset, asynchronous and active-low.
REQ-005 tpg_en_i  input  1  enables frame generation.
REQ-006 pattern_sel_i  input  2  pattern select: 0 solid, 1 ramp, 2 colour bars, 3 checkerboard.
REQ-007 width_i / height_i  input  DIM_W each  active pixels per line / lines per frame.
REQ-008 vblank_i  input  16  idle cycles inserted between frames.
REQ-009 solid_color_i  input  DATA_W  pixel value used by pattern 0.
REQ-010 m_axis_tdata/tvalid/tuser[0]/tlast  output  DATA_W/1/1/1  AXI4-Stream video master; tuser[0] is start-of-frame (SOF), tlast is end-of-line (EOL).
REQ-011 m_axis_tready  input  1  downstream ready.
REQ-012 frames_cnt_o  output  8  completed frames, wraps at 255->0; busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have three states, IDLE, ACTIVE and VBLANK, with these transitions:
- IDLE->ACTIVE when tpg_en_i=1 and width_i!=0 and height_i!=0.
- ACTIVE->VBLANK after the last beat of the last line is accepted.
- VBLANK->ACTIVE after vblank_i cycles if tpg_en_i=1, otherwise VBLANK->IDLE.
REQ-014 Timing: tvalid SHALL rise on the cycle after the IDLE->ACTIVE transition condition is sampled, and that first beat SHALL carry tuser[0]=1.
REQ-015 width_i, height_i, pattern_sel_i and solid_color_i SHALL be latched on entry to ACTIVE; changes mid-frame SHALL take effect only at the next frame.
REQ-016 A beat transfers when tvalid&tready; while tvalid=1 and tready=0, tdata/tuser/tlast SHALL hold stable.
REQ-017 tuser[0] SHALL be 1 only on pixel (x=0,y=0); tlast SHALL be 1 only on x=width-1.
REQ-018 The x counter SHALL wrap to 0 after x=width-1 and increment y; the frame ends at x=width-1, y=height-1.
REQ-019 Output is gapless: with tready held at 1, exactly width*height consecutive beats per frame.
REQ-020 Deasserting tpg_en_i mid-frame SHALL NOT truncate the frame; the frame completes and the FSM goes to IDLE after VBLANK.
REQ-021 vblank_i=0 SHALL produce back-to-back frames, with SOF on the beat immediately following the final tlast.
REQ-022 frames_cnt_o SHALL increment on acceptance of each frame's final beat.
REQ-023 Pattern values, with xe = x plus offset, taken modulo width:
- Ramp: {xe[4:0], xe[5:0], xe[4:0]}.
- Bars: 8 bars, each of width width>>3, indexed by a bar counter; xe past the 8th bar boundary stays in bar 7; colours in the table.
- Checker: white when xe[3]^y[3]=1, else black.
- No division or multiplication by non-constants.

Reset
REQ-024 With ARESETn=0, the following SHALL hold regardless of the clock:
- FSM in IDLE; tvalid, tuser and tlast at 0; tdata at 0.
- frames_cnt_o at 0, busy_o at 0, offset at 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately; the next frame after release SHALL start with SOF.

Configuration
REQ-026 Macro VIDEO_TPG_MOVE_EN: when defined, the offset SHALL increment by 1 at each frame end and wrap to 0 at width-1, scrolling patterns 1-3; when undefined, the offset SHALL be constant 0 and no offset register exists.

Structure
REQ-027 Package video_pkg SHALL hold:
- the pattern-select enum;
- the FSM state enum;
- the RGB565 colour constants and the 8-entry bar colour table.
REQ-028 The pixel-value generator SHALL be sub-module video_tpg_pattern: combinational, taking x, y, pattern and offset and returning tdata; the FSM and counters stay in video_tpg.

Verification
REQ-029 Basic frame: width=4, height=2, vblank=3, pattern 0, solid=16'hF800, tready=1. Expect 8 beats, all 16'hF800; tuser on beat 0; tlast on beats 3 and 7; 3 idle cycles; then the next SOF.
REQ-030 Backpressure: same configuration, tready toggled randomly. Expect tdata/tuser/tlast stable while stalled, the same 8-beat sequence, and frames_cnt_o incrementing once per frame.
REQ-031 Disable mid-frame: width=8, height=4, tpg_en_i dropped at beat 10. Expect all 32 beats, frames_cnt_o=1, then IDLE and busy_o=0.
REQ-032 Zero dimensions: width=0, tpg_en_i=1. Expect the FSM stays in IDLE and tvalid stays 0.
REQ-033 Reset mid-frame: ARESETn pulsed low asynchronously at beat 5. Expect outputs at 0 immediately; after release, a frame starts with tuser=1.
REQ-034 Move feature: VIDEO_TPG_MOVE_EN defined, pattern 1, width=64, vblank=0. Expect the frame-2 first pixel ramp value to correspond to xe=1, and the frame-65 first pixel to xe=0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern generator:
// pattern-select and FSM state enums, RGB565 colours and the bar table.
package video_pkg;

   typedef enum logic [1:0] {
      PAT_SOLID   = 2'd0,
      PAT_RAMP    = 2'd1,
      PAT_BARS    = 2'd2,
      PAT_CHECKER = 2'd3
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_VBLANK = 2'd2
   } state_e;

   localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
   localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
   localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
   localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
   localparam logic [15:0] RGB565_RED     = 16'hF800;
   localparam logic [15:0] RGB565_BLUE    = 16'h001F;
   localparam logic [15:0] RGB565_BLACK   = 16'h0000;

   // Classic colour-bar order, left to right.
   localparam logic [15:0] BAR_TABLE [0:7] = '{
      RGB565_WHITE, RGB565_YELLOW, RGB565_CYAN, RGB565_GREEN,
      RGB565_MAGENTA, RGB565_RED, RGB565_BLUE, RGB565_BLACK
   };

endpackage

// File: rtl/video_tpg_pattern.sv
// Combinational pixel generator: maps (x, y, offset) of the current frame
// to an RGB565 pixel for the selected pattern.
module video_tpg_pattern
   import video_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIM_W  = 12
) (
   input  logic [DIM_W-1:0]  x_i,
   input  logic [DIM_W-1:0]  y_i,
   input  logic [DIM_W-1:0]  width_i,
   input  logic [DIM_W-1:0]  offset_i,
   input  pattern_e          pattern_i,
   input  logic [DATA_W-1:0] solid_i,
   output logic [DATA_W-1:0] tdata_o
);

   logic [DIM_W:0]   xe_sum;
   logic [DIM_W:0]   xe_wrap;
   logic [DIM_W-1:0] xe;
   logic [DIM_W-1:0] bar_w;
   logic [DIM_W:0]   bound;
   logic [2:0]       bar_idx;
   logic             unused_y;

   assign unused_y = ^{y_i[DIM_W-1:4], y_i[2:0]};

   // Shifted x, reduced modulo width: x and offset are both below width,
   // so one conditional subtraction is enough.
   always_comb begin
      xe_sum  = {1'b0, x_i} + {1'b0, offset_i};
      xe_wrap = xe_sum;
      if (xe_sum >= {1'b0, width_i}) begin
         xe_wrap = xe_sum - {1'b0, width_i};
      end
      xe = xe_wrap[DIM_W-1:0];
   end

   // Bar counter: count how many bar boundaries xe has passed; boundaries
   // beyond the seventh are not considered, so the tail stays in bar 7.
   always_comb begin
      bar_w   = {3'b000, width_i[DIM_W-1:3]};
      bound   = '0;
      bar_idx = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         bound = bound + {1'b0, bar_w};
         if ({1'b0, xe} >= bound) begin
            bar_idx = 3'(k);
         end
      end
   end

   // Pattern select.
   always_comb begin
      tdata_o = solid_i;
      case (pattern_i)
         PAT_SOLID:   tdata_o = solid_i;
         PAT_RAMP:    tdata_o = DATA_W'({xe[4:0], xe[5:0], xe[4:0]});
         PAT_BARS:    tdata_o = DATA_W'(BAR_TABLE[bar_idx]);
         PAT_CHECKER: tdata_o = (xe[3] ^ y_i[3]) ? DATA_W'(RGB565_WHITE)
                                                 : DATA_W'(RGB565_BLACK);
         default:     tdata_o = solid_i;
      endcase
   end

endmodule

// File: rtl/video_tpg.sv
// Video test-pattern generator with an AXI4-Stream video master output.
// Frame FSM (IDLE/ACTIVE/VBLANK), pixel/line counters and frame counter
// live here; pixel values come from video_tpg_pattern.
// Optional macro VIDEO_TPG_MOVE_EN: scrolls patterns by one pixel per frame.
module video_tpg
   import video_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DIM_W  = 12
) (
   input  logic              ACLK,
   input  logic              ARESETn,
   input  logic              tpg_en_i,
   input  logic [1:0]        pattern_sel_i,
   input  logic [DIM_W-1:0]  width_i,
   input  logic [DIM_W-1:0]  height_i,
   input  logic [15:0]       vblank_i,
   input  logic [DATA_W-1:0] solid_color_i,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic [0:0]        m_axis_tuser,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [7:0]        frames_cnt_o,
   output logic              busy_o
);

   state_e            state_q, state_d;
   logic [DIM_W-1:0]  width_q, height_q;
   logic [DIM_W-1:0]  x_q, y_q;
   pattern_e          pat_q;
   logic [DATA_W-1:0] solid_q;
   logic [15:0]       vb_q;
   logic [7:0]        frames_q;
   logic [DIM_W-1:0]  offset_w;
   logic [DATA_W-1:0] pix_w;

   logic start_ok, beat, last_x, last_y, frame_end, load;

   assign start_ok  = tpg_en_i && (width_i != '0) && (height_i != '0);
   assign beat      = (state_q == ST_ACTIVE) && m_axis_tready;
   assign last_x    = (x_q == width_q - DIM_W'(1));
   assign last_y    = (y_q == height_q - DIM_W'(1));
   assign frame_end = beat && last_x && last_y;

   // FSM state register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, frame-parameter load strobe and stream outputs.
   // A zero vblank skips VBLANK entirely so the next SOF follows the
   // final tlast directly.
   always_comb begin
      state_d       = state_q;
      load          = 1'b0;
      m_axis_tvalid = (state_q == ST_ACTIVE);
      m_axis_tuser  = m_axis_tvalid && (x_q == '0) && (y_q == '0);
      m_axis_tlast  = m_axis_tvalid && last_x;
      m_axis_tdata  = m_axis_tvalid ? pix_w : '0;
      busy_o        = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE: begin
            if (start_ok) begin
               state_d = ST_ACTIVE;
               load    = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (frame_end) begin
               if (vblank_i != '0) begin
                  state_d = ST_VBLANK;
               end else if (start_ok) begin
                  state_d = ST_ACTIVE;
                  load    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_VBLANK: begin
            if (vb_q == '0) begin
               if (start_ok) begin
                  state_d = ST_ACTIVE;
                  load    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Frame parameters, pixel/line counters, blanking and frame counters.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         width_q  <= '0;
         height_q <= '0;
         pat_q    <= PAT_SOLID;
         solid_q  <= '0;
         x_q      <= '0;
         y_q      <= '0;
         vb_q     <= '0;
         frames_q <= '0;
      end else begin
         if (load) begin
            width_q  <= width_i;
            height_q <= height_i;
            pat_q    <= pattern_e'(pattern_sel_i);
            solid_q  <= solid_color_i;
            x_q      <= '0;
            y_q      <= '0;
         end else if (beat) begin
            if (last_x) begin
               x_q <= '0;
               y_q <= y_q + DIM_W'(1);
            end else begin
               x_q <= x_q + DIM_W'(1);
            end
         end
         if (frame_end && (vblank_i != '0)) begin
            vb_q <= vblank_i - 16'd1;
         end else if ((state_q == ST_VBLANK) && (vb_q != '0)) begin
            vb_q <= vb_q - 16'd1;
         end
         if (frame_end) begin
            frames_q <= frames_q + 8'd1;
         end
      end
   end

`ifdef VIDEO_TPG_MOVE_EN
   logic [DIM_W-1:0] offset_q, offset_d;

   // Scroll offset: advance at frame end, wrap at width-1; cleared on load
   // if the new frame is too narrow for it.
   always_comb begin
      offset_d = offset_q;
      if (frame_end) begin
         offset_d = (offset_q >= width_q - DIM_W'(1)) ? '0 : offset_q + DIM_W'(1);
      end
      if (load && (offset_d >= width_i)) begin
         offset_d = '0;
      end
   end

   // Scroll offset register.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         offset_q <= '0;
      end else begin
         offset_q <= offset_d;
      end
   end

   assign offset_w = offset_q;
`else
   assign offset_w = '0;
`endif

   assign frames_cnt_o = frames_q;

   video_tpg_pattern #(
      .DATA_W (DATA_W),
      .DIM_W  (DIM_W)
   ) u_pattern (
      .x_i       (x_q),
      .y_i       (y_q),
      .width_i   (width_q),
      .offset_i  (offset_w),
      .pattern_i (pat_q),
      .solid_i   (solid_q),
      .tdata_o   (pix_w)
   );

endmodule

// File: tb/tb_video_tpg.sv
// Self-checking bench for video_tpg: directed scenarios plus randomized
// configurations, scored against a frame-level reference model.
module tb_video_tpg;

   logic        ACLK = 1'b0;
   logic        ARESETn;
   logic        tpg_en;
   logic [1:0]  psel;
   logic [11:0] width, height;
   logic [15:0] vblank;
   logic [15:0] solid;
   logic [15:0] tdata;
   logic        tvalid;
   logic [0:0]  tuser;
   logic        tlast;
   logic        tready;
   logic [7:0]  frames;
   logic        busy;

   always #5 ACLK = ~ACLK;

   video_tpg #(.DATA_W(16), .DIM_W(12)) dut (
      .ACLK          (ACLK),
      .ARESETn       (ARESETn),
      .tpg_en_i      (tpg_en),
      .pattern_sel_i (psel),
      .width_i       (width),
      .height_i      (height),
      .vblank_i      (vblank),
      .solid_color_i (solid),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tuser  (tuser),
      .m_axis_tlast  (tlast),
      .m_axis_tready (tready),
      .frames_cnt_o  (frames),
      .busy_o        (busy)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        user;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   beat_t       hold;
   logic        hold_v;
   int          checks = 0;
   int          failures = 0;
   int          beats = 0;
   bit          got_sof;
   bit          bp_mode;
   int          model_off = 0;
   logic [15:0] first_pix;
   logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                             16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] model_pix(int pat, int x, int y, int off, int w, logic [15:0] s);
      int xe, bw, bar;
      logic [15:0] xv;
      xe = (x + off) % w;
      xv = 16'(xe);
      case (pat)
         0: return s;
         1: return {xv[4:0], xv[5:0], xv[4:0]};
         2: begin
            bw  = w / 8;
            bar = (bw == 0) ? 7 : xe / bw;
            if (bar > 7) bar = 7;
            return BARS[bar];
         end
         default: return ((((xe >> 3) ^ (y >> 3)) & 1) != 0) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   // Queue the expected beats of one frame using the current inputs.
   task automatic push_frame();
      beat_t e;
      int w, h;
      w = int'(width);
      h = int'(height);
      if (model_off >= w) model_off = 0;
      for (int y = 0; y < h; y++) begin
         for (int x = 0; x < w; x++) begin
            e.data = model_pix(int'(psel), x, y, model_off, w, solid);
            e.user = (x == 0) && (y == 0);
            e.last = (x == w - 1);
            exp_q.push_back(e);
         end
      end
`ifdef VIDEO_TPG_MOVE_EN
      model_off = (model_off + 1 >= w) ? 0 : model_off + 1;
`endif
   endtask

   task automatic set_cfg(int w, int h, int vb, int pat, logic [15:0] s);
      width  = 12'(w);
      height = 12'(h);
      vblank = 16'(vb);
      psel   = 2'(pat);
      solid  = s;
   endtask

   // One clock: drive tready after the edge, sample and score at negedge.
   task automatic cycle();
      beat_t e;
      @(posedge ACLK);
      #1;
      tready = bp_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge ACLK);
      got_sof = 0;
      if (hold_v) begin
         check("stall_valid", tvalid, 1);
         if (tvalid) begin
            check("stall_data", tdata, hold.data);
            check("stall_user", tuser, hold.user);
            check("stall_last", tlast, hold.last);
         end
      end
      if (tvalid && tready) begin
         beats++;
         if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("beat_data", tdata, e.data);
            check("beat_user", tuser, e.user);
            check("beat_last", tlast, e.last);
         end
         if (tuser[0]) begin
            got_sof   = 1;
            first_pix = tdata;
         end
      end
      hold_v = tvalid && !tready;
      hold   = '{tdata, tuser[0], tlast};
   endtask

   task automatic run_to_idle();
      int n = 0;
      while (busy && n < 3000) begin
         cycle();
         n++;
      end
      check("idle_reached", busy, 0);
      check("queue_empty", exp_q.size(), 0);
   endtask

   task automatic run_frames(int n, bit rnd);
      int f = 0;
      int budget = 0;
      int start;
      start = int'(frames);
      push_frame();
      tpg_en = 1;
      while (f < n && budget < 20000) begin
         cycle();
         budget++;
         if (got_sof) begin
            f++;
            if (f < n) begin
               if (rnd) begin
                  set_cfg($urandom_range(1, 24), $urandom_range(1, 5), $urandom_range(0, 3),
                          $urandom_range(0, 3), 16'($urandom));
               end
               push_frame();
            end else begin
               tpg_en = 0;
            end
         end
      end
      if (budget >= 20000) check("frames_timeout", 0, 1);
      tpg_en = 0;
      run_to_idle();
      check("frames_cnt", frames, 32'((start + n) & 255));
   endtask

   initial begin
      int b0, n, seen;
      ARESETn = 0;
      tpg_en  = 0;
      tready  = 1;
      bp_mode = 0;
      hold_v  = 0;
      set_cfg(4, 2, 3, 0, 16'hF800);

      // Reset state
      repeat (2) @(negedge ACLK);
      check("rst_valid", tvalid, 0);
      check("rst_data", tdata, 0);
      check("rst_user", tuser, 0);
      check("rst_last", tlast, 0);
      check("rst_frames", frames, 0);
      check("rst_busy", busy, 0);
      ARESETn = 1;
      @(negedge ACLK);

      // Basic frame timing: 8 gapless beats, 3 blank cycles, next SOF
      push_frame();
      push_frame();
      tpg_en = 1;
      cycle();
      check("basic_first_valid", tvalid, 1);
      check("basic_first_sof", tuser, 1);
      for (int i = 0; i < 7; i++) begin
         cycle();
         check("basic_gapless", tvalid, 1);
      end
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("basic_vblank", tvalid, 0);
      end
      cycle();
      check("basic_sof2", tvalid && tuser[0], 1);
      tpg_en = 0;
      run_to_idle();
      check("basic_frames", frames, 2);

      // Backpressure on the same configuration
      bp_mode = 1;
      run_frames(3, 0);

      // Disable mid-frame: the frame still completes
      bp_mode = 0;
      set_cfg(8, 4, 2, $urandom_range(0, 3), 16'($urandom));
      n = int'(frames);
      push_frame();
      tpg_en = 1;
      b0 = beats;
      for (int i = 0; i < 200 && (beats - b0) < 10; i++) cycle();
      tpg_en = 0;
      run_to_idle();
      check("dis_beats", beats - b0, 32);
      check("dis_frames", frames, 32'((n + 1) & 255));
      check("dis_busy", busy, 0);

      // Zero dimensions never leave IDLE
      set_cfg(0, 3, 1, 0, 16'h1234);
      tpg_en = 1;
      seen = 0;
      repeat (20) begin cycle(); seen = seen | tvalid | busy; end
      check("zero_w_idle", seen, 0);
      set_cfg(5, 0, 1, 0, 16'h1234);
      seen = 0;
      repeat (20) begin cycle(); seen = seen | tvalid | busy; end
      check("zero_h_idle", seen, 0);
      tpg_en = 0;

      // Asynchronous reset mid-frame
      set_cfg(8, 2, 1, 3, 16'h0);
      push_frame();
      tpg_en = 1;
      b0 = beats;
      for (int i = 0; i < 200 && (beats - b0) < 5; i++) cycle();
      #3 ARESETn = 0;
      #1;
      check("mrst_valid", tvalid, 0);
      check("mrst_data", tdata, 0);
      check("mrst_user", tuser, 0);
      check("mrst_last", tlast, 0);
      check("mrst_frames", frames, 0);
      check("mrst_busy", busy, 0);
      exp_q.delete();
      model_off = 0;
      hold_v = 0;
      @(posedge ACLK);
      @(negedge ACLK);
      ARESETn = 1;
      push_frame();
      cycle();
      check("mrst_sof", tvalid && tuser[0], 1);
      tpg_en = 0;
      run_to_idle();
      check("mrst_frames_after", frames, 1);

      // Randomized configurations with mid-frame input changes
      repeat (6) begin
         set_cfg($urandom_range(1, 24), $urandom_range(1, 5), $urandom_range(0, 3),
                 $urandom_range(0, 3), 16'($urandom));
         bp_mode = bit'($urandom_range(0, 1));
         run_frames($urandom_range(1, 3), 1);
      end

`ifdef VIDEO_TPG_MOVE_EN
      // Scrolling ramp: offset advances once per frame, wraps after 64
      bp_mode = 0;
      ARESETn = 0;
      exp_q.delete();
      model_off = 0;
      hold_v = 0;
      @(negedge ACLK);
      ARESETn = 1;
      set_cfg(64, 1, 0, 1, 16'h0);
      push_frame();
      tpg_en = 1;
      n = 0;
      for (int i = 0; i < 8000 && n < 65; i++) begin
         cycle();
         if (got_sof) begin
            n++;
            if (n == 2) check("move_f2", first_pix, 16'h0821);
            if (n == 65) check("move_f65", first_pix, 16'h0000);
            if (n < 65) push_frame(); else tpg_en = 0;
         end
      end
      check("move_frames_seen", n, 65);
      tpg_en = 0;
      run_to_idle();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
